// File: rtl/npu_pkg.sv
// -----------------------------------------------------------------------------
// npu_pkg
// Shared definitions for the npu host interface: layout of the six-word config
// header, field widths, num_layers encodings, the host FSM state type and small
// helpers for turning encoded neuron counts into word counts.
// -----------------------------------------------------------------------------
package npu_pkg;

  // Config header word order
  localparam int NUM_CFG_WORDS  = 6;
  localparam int CFG_NUM_LAYERS = 0;
  localparam int CFG_NN0        = 1;
  localparam int CFG_NN1        = 2;
  localparam int CFG_NN2        = 3;
  localparam int CFG_NN3        = 4;
  localparam int CFG_DO_ACT     = 5;

  // Field widths
  localparam int NL_W        = 2;
  localparam int NN_W        = 5;
  localparam int ACT_W       = 3;
  localparam int MAX_NEURONS = 32;
  // Wide enough for a decoded count (1..32) and for count+1 (up to 33)
  localparam int NEUR_W      = 6;

  typedef enum logic [NL_W-1:0] {
    NL_ZERO_HIDDEN = 2'd0,
    NL_ONE_HIDDEN  = 2'd1,
    NL_TWO_HIDDEN  = 2'd2,
    NL_ILLEGAL     = 2'd3
  } num_layers_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_CFG,
    ST_BODY,
    ST_WAIT_RDY,
    ST_READ,
    ST_ERR
  } state_e;

  // Encoded field n means n+1 neurons
  function automatic logic [NEUR_W-1:0] neurons(input logic [NN_W-1:0] n);
    return NEUR_W'(n) + NEUR_W'(1);
  endfunction

  // Words for one layer: each output neuron has N_in weights plus a bias
  function automatic logic [2*NEUR_W-1:0] layer_words(input logic [NEUR_W-1:0] n_out,
                                                      input logic [NEUR_W-1:0] n_in);
    return (2*NEUR_W)'(n_out) * (2*NEUR_W)'(n_in + NEUR_W'(1));
  endfunction

endpackage

// File: rtl/npu_job_len.sv
// -----------------------------------------------------------------------------
// npu_job_len
// Combinational length of a job body (weights+biases of every layer followed
// by the input vector) from the latched config fields.
//   num_layers  in  NL_W   number of hidden layers (0..2; 3 is illegal)
//   nn0..nn3    in  NN_W   encoded neuron counts (n means n+1)
//   len         out CNT_W  body word count
// -----------------------------------------------------------------------------
module npu_job_len
  import npu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic [NL_W-1:0]  num_layers,
  input  logic [NN_W-1:0]  nn0,
  input  logic [NN_W-1:0]  nn1,
  input  logic [NN_W-1:0]  nn2,
  input  logic [NN_W-1:0]  nn3,
  output logic [CNT_W-1:0] len
);

  // node[k] is the neuron count of the k-th layer in the chain; the output
  // layer (nn3) is placed right after the last hidden layer.
  logic [NEUR_W-1:0]   node [4];
  logic [2*NEUR_W-1:0] prod [3];

  always_comb begin
    node[0] = neurons(nn0);
    node[1] = neurons(nn1);
    node[2] = neurons(nn2);
    node[3] = neurons(nn3);
    case (num_layers)
      NL_ZERO_HIDDEN: node[1] = neurons(nn3);
      NL_ONE_HIDDEN:  node[2] = neurons(nn3);
      default: ;
    endcase
  end

  // Layer gi (node[gi] -> node[gi+1]) exists when gi <= hidden count
  for (genvar gi = 0; gi < 3; gi++) begin : g_layer
    assign prod[gi] = (gi <= int'(num_layers)) ? layer_words(node[gi+1], node[gi]) : '0;
  end

  assign len = CNT_W'(prod[0]) + CNT_W'(prod[1]) + CNT_W'(prod[2]) + CNT_W'(node[0]);

endmodule

// File: rtl/npu_host_if.sv
// -----------------------------------------------------------------------------
// npu_host_if
// Host-side bus master for the npu. Replays one job (config header, body) from
// the upstream word stream onto the npu bus with we, waits for npu_ready,
// reads back N3 result words with oe and forwards them downstream.
//   clk, rst              clock, asynchronous active-high reset
//   start                 begin a job (only honoured in IDLE)
//   in_data/valid/ready   upstream job words; in_ready = word consumed
//   out_data/valid/ready  result words, output neuron order
//   npu_we, npu_oe        npu write / output enable
//   npu_ready             npu results available
//   bus_dout, bus_drive   value and tristate enable for the npu data bus
//   bus_din               sampled npu data bus
//   busy                  not IDLE
//   err                   sticky error, cleared by the next accepted start
// -----------------------------------------------------------------------------
module npu_host_if
  import npu_pkg::*;
#(
  parameter int          DW          = 32,
  parameter int          CNT_W       = 16,
  parameter int unsigned RDY_TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          npu_we,
  output logic          npu_oe,
  input  logic          npu_ready,
  output logic [DW-1:0] bus_dout,
  output logic          bus_drive,
  input  logic [DW-1:0] bus_din,
  output logic          busy,
  output logic          err
);

  localparam int TO_W  = (RDY_TIMEOUT < 2) ? 1 : $clog2(RDY_TIMEOUT);
  localparam int CFG_W = $clog2(NUM_CFG_WORDS);

  state_e             state_reg, state_next;
  logic [CFG_W-1:0]   cfg_cnt_reg;
  logic [CNT_W-1:0]   body_cnt_reg;
  logic [CNT_W-1:0]   len_reg;
  logic [CNT_W-1:0]   len_comb;
  logic [TO_W-1:0]    wait_cnt_reg;
  logic [NEUR_W-1:0]  res_cnt_reg;
  logic [NL_W-1:0]    num_layers_reg;
  logic [NN_W-1:0]    nn_reg [4];
  logic [DW-1:0]      res_data_reg;
  logic               res_valid_reg;
  logic               err_reg;
  logic [NEUR_W-1:0]  n3;
  logic               cfg_take;
  logic               timeout;
  logic               read_done;

  assign n3        = neurons(nn_reg[3]);
  assign cfg_take  = (state_reg == ST_CFG) && in_valid;
  assign timeout   = (RDY_TIMEOUT != 0) && (wait_cnt_reg == TO_W'(RDY_TIMEOUT - 1));
  assign read_done = (res_cnt_reg == n3) && (!res_valid_reg || out_ready);

  npu_job_len #(.CNT_W(CNT_W)) u_job_len (
    .num_layers (num_layers_reg),
    .nn0        (nn_reg[0]),
    .nn1        (nn_reg[1]),
    .nn2        (nn_reg[2]),
    .nn3        (nn_reg[3]),
    .len        (len_comb)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next state. A missing upstream word during CFG/BODY aborts because the
  // npu cannot be stalled.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (start) state_next = ST_PRE;
      ST_PRE:      state_next = ST_CFG;
      ST_CFG: begin
        if (!in_valid)
          state_next = ST_ERR;
        else if (cfg_cnt_reg == CFG_W'(NUM_CFG_WORDS - 1))
          state_next = (num_layers_reg == NL_ILLEGAL) ? ST_ERR : ST_BODY;
      end
      ST_BODY: begin
        if (!in_valid)                              state_next = ST_ERR;
        else if (body_cnt_reg == len_reg - CNT_W'(1)) state_next = ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (npu_ready)    state_next = ST_READ;
        else if (timeout) state_next = ST_ERR;
      end
      ST_READ:     if (read_done) state_next = ST_IDLE;
      ST_ERR:      state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Outputs. we follows in_valid in CFG/BODY so a dropped word is never
  // written; oe only fires when the single result slot is (or becomes) free.
  always_comb begin
    npu_we   = 1'b0;
    npu_oe   = 1'b0;
    in_ready = 1'b0;
    bus_dout = '0;
    case (state_reg)
      ST_PRE: npu_we = 1'b1;
      ST_CFG, ST_BODY: begin
        npu_we   = in_valid;
        in_ready = in_valid;
        bus_dout = in_valid ? in_data : '0;
      end
      ST_READ: npu_oe = (res_cnt_reg < n3) && (!res_valid_reg || out_ready);
      default: ;
    endcase
  end

  assign bus_drive = npu_we;
  assign busy      = (state_reg != ST_IDLE);
  assign out_data  = res_data_reg;
  assign out_valid = res_valid_reg;
  assign err       = err_reg;

  // Config field capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      num_layers_reg <= '0;
    else if (cfg_take && cfg_cnt_reg == CFG_W'(CFG_NUM_LAYERS))
      num_layers_reg <= in_data[NL_W-1:0];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_nn
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        nn_reg[gi] <= '0;
      else if (cfg_take && cfg_cnt_reg == CFG_W'(CFG_NN0 + gi))
        nn_reg[gi] <= in_data[NN_W-1:0];
    end
  end

  // Counters, body length, result slot and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_cnt_reg   <= '0;
      body_cnt_reg  <= '0;
      len_reg       <= '0;
      wait_cnt_reg  <= '0;
      res_cnt_reg   <= '0;
      res_data_reg  <= '0;
      res_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      if (state_reg != ST_CFG) cfg_cnt_reg <= '0;
      else if (in_valid)       cfg_cnt_reg <= cfg_cnt_reg + CFG_W'(1);

      if (state_reg != ST_BODY) body_cnt_reg <= '0;
      else if (in_valid)        body_cnt_reg <= body_cnt_reg + CNT_W'(1);

      if (state_reg == ST_CFG && state_next == ST_BODY) len_reg <= len_comb;

      if (state_reg != ST_WAIT_RDY) wait_cnt_reg <= '0;
      else                          wait_cnt_reg <= wait_cnt_reg + TO_W'(1);

      if (state_reg == ST_IDLE) res_cnt_reg <= '0;
      else if (npu_oe)          res_cnt_reg <= res_cnt_reg + NEUR_W'(1);

      // Capture and downstream accept may coincide in the same cycle
      if (npu_oe) res_data_reg <= bus_din;
      res_valid_reg <= npu_oe || (res_valid_reg && !out_ready);

      if (state_next == ST_ERR)               err_reg <= 1'b1;
      else if (state_reg == ST_IDLE && start) err_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_npu_host_if.sv
// -----------------------------------------------------------------------------
// tb_npu_host_if
// Directed jobs against npu_host_if with a stub npu that returns preloaded
// result words. Expected bus writes and result words are queued when a job is
// issued; a forked monitor pops and compares them as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_npu_host_if;

  localparam int DW = 32;
  localparam logic [DW-1:0] T1_RES = 32'h0002_C000;  // 2.75 in Q16.16

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          npu_we, npu_oe;
  logic          npu_ready = 1'b0;
  logic [DW-1:0] bus_dout;
  logic          bus_drive;
  logic [DW-1:0] bus_din;
  logic          busy, err;

  always #5 clk = ~clk;

  npu_host_if #(.DW(DW), .CNT_W(16), .RDY_TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .npu_we(npu_we), .npu_oe(npu_oe), .npu_ready(npu_ready),
    .bus_dout(bus_dout), .bus_drive(bus_drive), .bus_din(bus_din),
    .busy(busy), .err(err)
  );

  // Stub npu: presents its k-th result word until the k-th oe cycle
  logic [DW-1:0] npu_res [32];
  int            npu_idx;
  always @(posedge clk or posedge rst) begin
    if (rst)                 npu_idx <= 0;
    else if (start && !busy) npu_idx <= 0;
    else if (npu_oe)         npu_idx <= npu_idx + 1;
  end
  assign bus_din = npu_res[npu_idx[4:0]];

  int            n_vec = 0;
  int            n_bad = 0;
  logic [DW-1:0] job_w [$];
  logic [DW-1:0] exp_bus [$];
  logic [DW-1:0] exp_res [$];
  logic [DW-1:0] res_a [8];
  logic [DW-1:0] res_b [8];
  int            we_total = 0;
  int            oe_total = 0;
  int            drop_idx = -1;
  int            rst_idx = -1;
  int            ready_mode = 0;  // 0: always, 1: one cycle in three, 2: never

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("bus_drive", 32'(bus_drive), 32'(npu_we));
        check("we_oe_excl", 32'(npu_we & npu_oe), 0);
        if (npu_we) begin
          we_total++;
          check("bus_pending", 32'(exp_bus.size() > 0), 1);
          if (exp_bus.size() > 0) check("bus_word", bus_dout, exp_bus.pop_front());
        end
        if (npu_oe) begin
          oe_total++;
          check("oe_gate", 32'(out_valid & ~out_ready), 0);
        end
        if (out_valid && out_ready) begin
          check("res_pending", 32'(exp_res.size() > 0), 1);
          if (exp_res.size() > 0) begin
            e = exp_res.pop_front();
            check("res_data", out_data, e);
            $display("result: data=%h expected=%h", out_data, e);
          end
        end
      end
    end
  endtask

  task automatic drive_out_ready();
    int cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'b0;
      endcase
    end
  endtask

  // Called on a negedge: asserts reset, checks outputs, releases after an edge
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_ctrl", 32'({in_ready, out_valid, npu_we, npu_oe, bus_drive, busy, err}), 0);
    check("rst_bus_dout", bus_dout, 0);
    check("rst_out_data", out_data, 0);
    exp_bus.delete();
    exp_res.delete();
    npu_ready = 1'b0;
    in_valid  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset applied");
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (busy && guard < 3000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("job_done", 32'(busy), 0);
  endtask

  task automatic run_job(input bit ready_en, input bit wait_done);
    int i = 0;
    int guard = 0;
    npu_ready = 1'b0;
    exp_bus.push_back('0);  // lead-in word
    for (int k = 0; k < job_w.size(); k++)
      if ((drop_idx < 0 || k < drop_idx) && (rst_idx < 0 || k <= rst_idx))
        exp_bus.push_back(job_w[k]);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("start_clears_err", 32'(err), 0);
    check("busy_after_start", 32'(busy), 1);
    while (i < job_w.size() && guard < 4000) begin
      in_valid = (i != drop_idx);
      in_data  = job_w[i];
      @(negedge clk);
      if (i == drop_idx) begin
        check("drop_we", 32'(npu_we), 0);
        check("drop_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        check("drop_err", 32'(err), 1);
        break;
      end
      if (i == rst_idx) begin
        do_reset();
        break;
      end
      if (in_ready) i++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    check("feed_guard", 32'(guard < 4000), 1);
    if (ready_en && drop_idx < 0 && rst_idx < 0) begin
      repeat (3) @(posedge clk);
      #1 npu_ready = 1'b1;
    end
    if (wait_done) wait_idle();
    $display("job: words=%0d drop=%0d rst=%0d err=%0b", job_w.size(), drop_idx, rst_idx, err);
  endtask

  task automatic check_job(input string tag, input int we0, input int oe0,
                           input int we_exp, input int oe_exp, input bit err_exp);
    check({tag, "_we_cycles"}, 32'(we_total - we0), 32'(we_exp));
    check({tag, "_oe_cycles"}, 32'(oe_total - oe0), 32'(oe_exp));
    check({tag, "_err"}, 32'(err), 32'(err_exp));
    check({tag, "_res_left"}, 32'(exp_res.size()), 0);
    check({tag, "_bus_left"}, 32'(exp_bus.size()), 0);
  endtask

  // 0 hidden, N0=2, N3=1: w=[0.5,0.25], bias=1.0, x=[2.0,3.0] (Q16.16)
  task automatic load_t1();
    job_w = '{32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0,
              32'h0000_8000, 32'h0000_4000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
    npu_res[0] = T1_RES;
    exp_res.push_back(T1_RES);
  endtask

  // 1 hidden, all layers N=8: body 8*9 + 8*9 + 8 = 152 words
  task automatic load_t2();
    job_w = '{32'd1, 32'd7, 32'd7, 32'd0, 32'd7, 32'd0};
    for (int k = 0; k < 152; k++) job_w.push_back(32'hB000_0000 | 32'(k));
  endtask

  initial begin
    int we0, oe0, n, guard;
    res_a = '{32'h0001_8000, 32'h0000_4000, 32'h0002_2000, 32'h0000_0000,
              32'h0003_1000, 32'h0000_C000, 32'h0004_0000, 32'h0001_0800};
    res_b = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004,
              32'hA000_0005, 32'hA000_0006, 32'hA000_0007, 32'hA000_0008};
    fork
      monitor();
      drive_out_ready();
    join_none

    repeat (3) @(negedge clk);
    do_reset();

    // T1: smallest job, one result
    load_t1();
    we0 = we_total; oe0 = oe_total;
    run_job(1'b1, 1'b1);
    check_job("t1", we0, oe0, 12, 1, 1'b0);

    // T2: 1-hidden job, 8 results in order
    load_t2();
    for (int k = 0; k < 8; k++) begin npu_res[k] = res_a[k]; exp_res.push_back(res_a[k]); end
    we0 = we_total; oe0 = oe_total;
    run_job(1'b1, 1'b1);
    check_job("t2", we0, oe0, 159, 8, 1'b0);

    // T3: downstream accepts one cycle in three
    ready_mode = 1;
    for (int k = 0; k < 8; k++) begin npu_res[k] = res_b[k]; exp_res.push_back(res_b[k]); end
    we0 = we_total; oe0 = oe_total;
    run_job(1'b1, 1'b1);
    check_job("t3", we0, oe0, 159, 8, 1'b0);
    ready_mode = 0;

    // T4: upstream gap on body word 40, then a clean job clears err
    drop_idx = 46;
    we0 = we_total; oe0 = oe_total;
    run_job(1'b1, 1'b1);
    drop_idx = -1;
    check_job("t4", we0, oe0, 47, 0, 1'b1);
    load_t1();
    we0 = we_total; oe0 = oe_total;
    run_job(1'b1, 1'b1);
    check_job("t4b", we0, oe0, 12, 1, 1'b0);

    // T5a: illegal num_layers aborts after the header
    job_w = '{32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    we0 = we_total; oe0 = oe_total;
    run_job(1'b0, 1'b1);
    check_job("t5a", we0, oe0, 7, 0, 1'b1);

    // T5b: npu_ready never comes; err after exactly 100 waiting cycles
    job_w = '{32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0,
              32'h0000_8000, 32'h0000_4000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
    we0 = we_total; oe0 = oe_total;
    run_job(1'b0, 1'b0);
    n = 0; guard = 0;
    while (!err && guard < 400) begin
      @(negedge clk);
      if (busy && !npu_we) n++;
      @(posedge clk); #1;
      guard++;
    end
    check("t5b_timeout_cycles", 32'(n), 100);
    wait_idle();
    check_job("t5b", we0, oe0, 12, 0, 1'b1);

    // T6a: reset in the middle of the body
    load_t2();
    rst_idx = 66;
    run_job(1'b1, 1'b1);
    rst_idx = -1;

    // T6b: downstream stalled in READ: one capture, oe then held low; reset
    ready_mode = 2;
    for (int k = 0; k < 8; k++) begin npu_res[k] = res_a[k]; exp_res.push_back(res_a[k]); end
    oe0 = oe_total;
    run_job(1'b1, 1'b0);
    repeat (25) @(posedge clk);
    #1;
    check("t6b_oe_stall", 32'(oe_total - oe0), 1);
    check("t6b_out_valid", 32'(out_valid), 1);
    check("t6b_out_data", out_data, res_a[0]);
    check("t6b_oe_low", 32'(npu_oe), 0);
    @(negedge clk);
    do_reset();
    ready_mode = 0;

    // T6c: fresh job after reset
    load_t1();
    we0 = we_total; oe0 = oe_total;
    run_job(1'b1, 1'b1);
    check_job("t6c", we0, oe0, 12, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
